// File: rtl/warp_issue_ctrl.sv
// Purpose: sequences one warp -- fetches, decodes and broadcasts instructions to NUM_LANES lanes, then drains.
// Latency: fetch-to-issue is one cycle after imem_valid; minimum issue period is 2 cycles (FETCH+ISSUE).
// Backpressure: imem_req is held with a stable imem_addr until imem_valid; DRAIN waits for all masked lanes.
module warp_issue_ctrl #(
    parameter int NUM_LANES = 4,
    parameter int PC_WIDTH  = 8,
    parameter int MAX_INSTR = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [PC_WIDTH-1:0]  base_pc,
    input  logic [NUM_LANES-1:0] lane_mask,
    output logic                 imem_req,
    output logic [PC_WIDTH-1:0]  imem_addr,
    input  logic                 imem_valid,
    input  logic [31:0]          imem_data,
    output logic [2:0]           type_instr,
    output logic [4:0]           regnum_1,
    output logic [4:0]           regnum_2,
    output logic [4:0]           dest_reg,
    output logic [5:0]           shammt,
    output logic [NUM_LANES-1:0] lane_active,
    input  logic [NUM_LANES-1:0] lane_complete,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun,
    output logic [7:0]           instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_FORCE_EXIT,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [2:0] OP_EXIT = 3'b111;
    // Budget counter only needs to reach MAX_INSTR; the visible count saturates separately at 255.
    localparam int         BW      = $clog2(MAX_INSTR + 1);
    localparam logic [BW-1:0] BUDGET_LAST = BW'(MAX_INSTR - 1);

    state_t               state_q,  state_d;
    logic [PC_WIDTH-1:0]  pc_q,     pc_d;
    logic [NUM_LANES-1:0] mask_q,   mask_d;
    logic [BW-1:0]        budget_q, budget_d;
    logic                 req_q,    req_d;
    logic [PC_WIDTH-1:0]  addr_q,   addr_d;
    logic [2:0]           type_q,   type_d;
    logic [4:0]           rs1_q,    rs1_d;
    logic [4:0]           rs2_q,    rs2_d;
    logic [4:0]           dest_q,   dest_d;
    logic [5:0]           sh_q,     sh_d;
    logic [NUM_LANES-1:0] act_q,    act_d;
    logic                 busy_q,   busy_d;
    logic                 done_q,   done_d;
    logic                 ovr_q,    ovr_d;
    logic [7:0]           cnt_q,    cnt_d;

    // Low byte of the instruction word carries no field.
    logic unused_imem_bits;
    assign unused_imem_bits = ^imem_data[7:0];

    // Next-state and next-output logic; every output is registered so lanes see glitch-free controls.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        mask_d   = mask_q;
        budget_d = budget_q;
        req_d    = 1'b0;
        addr_d   = addr_q;
        type_d   = OP_EXIT;
        rs1_d    = '0;
        rs2_d    = '0;
        dest_d   = '0;
        sh_d     = '0;
        act_d    = '0;
        busy_d   = 1'b1;
        done_d   = 1'b0;
        ovr_d    = ovr_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    pc_d     = base_pc;
                    mask_d   = lane_mask;
                    budget_d = '0;
                    cnt_d    = '0;
                    ovr_d    = 1'b0;
                    busy_d   = 1'b1;
                    if (lane_mask == '0) begin
                        // Nothing to run: skip straight to the completion pulse.
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                        req_d   = 1'b1;
                        addr_d  = base_pc;
                    end
                end
            end

            S_FETCH: begin
                if (imem_valid) begin
                    state_d = S_ISSUE;
                    type_d  = imem_data[31:29];
                    dest_d  = imem_data[28:24];
                    rs1_d   = imem_data[23:19];
                    rs2_d   = imem_data[18:14];
                    sh_d    = imem_data[13:8];
                    act_d   = mask_q;
                end else begin
                    req_d = 1'b1;
                end
            end

            S_ISSUE: begin
                pc_d     = pc_q + 1'b1;
                budget_d = budget_q + 1'b1;
                cnt_d    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                if (type_q == OP_EXIT) begin
                    state_d = S_DRAIN;
                end else if (budget_q == BUDGET_LAST) begin
                    // Budget exhausted without EXIT: lanes get a synthetic EXIT.
                    state_d = S_FORCE_EXIT;
                    act_d   = mask_q;
                    ovr_d   = 1'b1;
                end else begin
                    state_d = S_FETCH;
                    req_d   = 1'b1;
                    addr_d  = pc_q + 1'b1;
                end
            end

            S_FORCE_EXIT: begin
                state_d = S_DRAIN;
            end

            S_DRAIN: begin
                if ((lane_complete & mask_q) == mask_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered-output update with asynchronous reset to the idle drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            mask_q   <= '0;
            budget_q <= '0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            type_q   <= OP_EXIT;
            rs1_q    <= '0;
            rs2_q    <= '0;
            dest_q   <= '0;
            sh_q     <= '0;
            act_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            mask_q   <= mask_d;
            budget_q <= budget_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            type_q   <= type_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            dest_q   <= dest_d;
            sh_q     <= sh_d;
            act_q    <= act_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign type_instr  = type_q;
    assign regnum_1    = rs1_q;
    assign regnum_2    = rs2_q;
    assign dest_reg    = dest_q;
    assign shammt      = sh_q;
    assign lane_active = act_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign overrun     = ovr_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_warp_issue_ctrl.sv
// Purpose: self-checking bench for warp_issue_ctrl; an expected per-cycle output trace is built per warp.
// Latency: trace entry 0 is the cycle after the start edge; imem responder latency is programmable.
// Backpressure: responder holds imem_valid low for lat cycles of imem_req; lanes complete after a set drain wait.
module tb_warp_issue_ctrl;

    localparam int MAXI = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  base_pc;
    logic [3:0]  lane_mask;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid;
    logic [31:0] imem_data;
    logic [2:0]  type_instr;
    logic [4:0]  regnum_1, regnum_2, dest_reg;
    logic [5:0]  shammt;
    logic [3:0]  lane_active;
    logic [3:0]  lane_complete;
    logic        busy, done, overrun;
    logic [7:0]  instr_count;

    warp_issue_ctrl #(.NUM_LANES(4), .PC_WIDTH(8), .MAX_INSTR(MAXI)) dut (
        .clk(clk), .rst(rst), .start(start), .base_pc(base_pc), .lane_mask(lane_mask),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
        .type_instr(type_instr), .regnum_1(regnum_1), .regnum_2(regnum_2), .dest_reg(dest_reg),
        .shammt(shammt), .lane_active(lane_active), .lane_complete(lane_complete),
        .busy(busy), .done(done), .overrun(overrun), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       req;
        logic [7:0] addr;
        logic [2:0] typ;
        logic [4:0] dst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [5:0] sh;
        logic [3:0] act;
        logic       busy;
        logic       done;
        logic       ovr;
        logic [7:0] cnt;
    } obs_t;

    logic [31:0] mem [256];
    obs_t        exp_q [$];
    logic [3:0]  lc_q  [$];
    int          lat = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    function automatic logic [31:0] instr(input logic [2:0] t, input int d, input int r1, input int r2, input int sh);
        logic [31:0] w;
        w = {t, 5'(d), 5'(r1), 5'(r2), 6'(sh), 8'h00};
        return w;
    endfunction

    function automatic obs_t mk(input logic req, input logic [7:0] addr, input logic [2:0] typ,
                                input logic [4:0] dst, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [5:0] sh, input logic [3:0] act, input logic bsy,
                                input logic dn, input logic ovr, input logic [7:0] cnt);
        obs_t o;
        o.req = req; o.addr = addr; o.typ = typ; o.dst = dst; o.rs1 = rs1; o.rs2 = rs2;
        o.sh = sh; o.act = act; o.busy = bsy; o.done = dn; o.ovr = ovr; o.cnt = cnt;
        return o;
    endfunction

    function automatic obs_t get_obs();
        return mk(imem_req, imem_addr, type_instr, dest_reg, regnum_1, regnum_2, shammt,
                  lane_active, busy, done, overrun, instr_count);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // imem_addr only matters while imem_req is expected high.
    task automatic chk_obs(input string name, input obs_t got, input obs_t want);
        if (!want.req) begin
            got.addr  = '0;
            want.addr = '0;
        end
        chk(name, 64'(got), 64'(want));
    endtask

    // Expected warp trace from the rules: each instruction costs lat+1 fetch cycles and one issue
    // cycle; budget exhaustion adds one forced EXIT; drain lasts dwait+1 cycles; then done, idle.
    task automatic build(input logic [7:0] base, input logic [3:0] mask, input int dwait);
        logic [7:0]  pc;
        logic [7:0]  cnt;
        logic [31:0] w;
        int          issued;
        exp_q.delete();
        lc_q.delete();
        pc = base; cnt = 0; issued = 0;
        if (mask == 4'b0) begin
            exp_q.push_back(mk(0, 0, 3'b111, 0, 0, 0, 0, 0, 1, 1, 0, 0)); lc_q.push_back(4'b0);
            exp_q.push_back(mk(0, 0, 3'b111, 0, 0, 0, 0, 0, 0, 0, 0, 0)); lc_q.push_back(4'b0);
            return;
        end
        for (int guard = 0; guard < 300; guard++) begin
            for (int k = 0; k <= lat; k++) begin
                exp_q.push_back(mk(1, pc, 3'b111, 0, 0, 0, 0, 0, 1, 0, 0, cnt));
                lc_q.push_back(4'b0);
            end
            w = mem[pc];
            exp_q.push_back(mk(0, 0, w[31:29], w[28:24], w[23:19], w[18:14], w[13:8], mask, 1, 0, 0, cnt));
            lc_q.push_back(4'b0);
            issued++;
            cnt = (cnt == 8'd255) ? cnt : cnt + 8'd1;
            pc  = pc + 8'd1;
            if (w[31:29] == 3'b111) break;
            if (issued == MAXI) begin
                exp_q.push_back(mk(0, 0, 3'b111, 0, 0, 0, 0, mask, 1, 0, 1, cnt));
                lc_q.push_back(4'b0);
                break;
            end
        end
        for (int k = 0; k <= dwait; k++) begin
            exp_q.push_back(mk(0, 0, 3'b111, 0, 0, 0, 0, 0, 1, 0, exp_q[$].ovr, cnt));
            lc_q.push_back((k == dwait) ? mask : 4'b0);
        end
        exp_q.push_back(mk(0, 0, 3'b111, 0, 0, 0, 0, 0, 1, 1, exp_q[$].ovr, cnt)); lc_q.push_back(4'b0);
        exp_q.push_back(mk(0, 0, 3'b111, 0, 0, 0, 0, 0, 0, 0, exp_q[$].ovr, cnt)); lc_q.push_back(4'b0);
    endtask

    // Launch a warp from IDLE (called at a negedge), check every cycle against the trace,
    // then check hand-computed totals.
    task automatic run_warp(input string name, input logic [7:0] base, input logic [3:0] mask,
                            input int latv, input int dwait, input bit mid_start,
                            input int x_cnt, input int x_ovr, input int x_req, input int x_iss);
        int req_n, done_n, iss_n;
        req_n = 0; done_n = 0; iss_n = 0;
        lat = latv;
        build(base, mask, dwait);
        base_pc = base; lane_mask = mask; start = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (mid_start && i == 1) begin
                start = 1'b1; base_pc = 8'hAA; lane_mask = 4'b0101;
            end
            chk_obs($sformatf("%s_cyc%0d", name, i), get_obs(), exp_q[i]);
            lane_complete = lc_q[i];
            if (imem_req) req_n++;
            if (done) done_n++;
            if (lane_active != 0 && type_instr != 3'b111) iss_n++;
        end
        start = 1'b0;
        chk({name, "_count"}, 64'(instr_count), 64'(x_cnt));
        chk({name, "_overrun"}, 64'(overrun), 64'(x_ovr));
        chk({name, "_done_pulses"}, 64'(done_n), 64'd1);
        chk({name, "_req_cycles"}, 64'(req_n), 64'(x_req));
        chk({name, "_issues"}, 64'(iss_n), 64'(x_iss));
    endtask

    // Memory responder: answers after lat waiting cycles of imem_req; stray valids when idle.
    initial begin
        int wcnt;
        wcnt = 0;
        imem_valid = 1'b0;
        imem_data  = '0;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                if (wcnt == lat) begin
                    imem_valid = 1'b1; imem_data = mem[imem_addr]; wcnt = 0;
                end else begin
                    imem_valid = 1'b0; wcnt++;
                end
            end else begin
                wcnt = 0;
                imem_valid = 1'($urandom_range(0, 1));
                imem_data  = $urandom;
            end
        end
    end

    initial begin
        obs_t rst_obs;
        rst_obs = mk(0, 0, 3'b111, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int a = 0; a < 256; a++) mem[a] = instr(3'b111, 0, 0, 0, 0);
        rst = 1'b1; start = 1'b0; base_pc = '0; lane_mask = '0; lane_complete = '0;
        #12;
        chk("reset_state", 64'(get_obs()), 64'(rst_obs));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", 64'(get_obs()), 64'(rst_obs));

        // 1: ADD d3 r1 r2 then EXIT, one-cycle imem latency
        mem[8'h10] = instr(3'b000, 3, 1, 2, 0);
        mem[8'h11] = instr(3'b111, 0, 0, 0, 0);
        lat = 1;
        build(8'h10, 4'b1011, 2);
        chk("t1_model_len", 64'(exp_q.size()), 64'd11);
        chk("t1_model_add", {exp_q[2].typ, exp_q[2].dst, exp_q[2].rs1, exp_q[2].rs2, exp_q[2].act},
            {3'b000, 5'd3, 5'd1, 5'd2, 4'b1011});
        run_warp("t1", 8'h10, 4'b1011, 1, 2, 0, 2, 0, 4, 1);

        // 2: three-cycle imem delay, start pulsed mid-warp
        mem[8'h20] = instr(3'b001, 5, 6, 7, 9);
        mem[8'h21] = instr(3'b111, 0, 0, 0, 0);
        run_warp("t2", 8'h20, 4'b1111, 3, 0, 1, 2, 0, 8, 1);

        // 3: six ADDs, budget of 4 forces EXIT
        for (int a = 0; a < 6; a++) mem[8'h30 + a] = instr(3'b000, a + 1, a, a + 2, a);
        lat = 0;
        build(8'h30, 4'b0110, 1);
        chk("t3_model_len", 64'(exp_q.size()), 64'd13);
        chk("t3_model_force", {exp_q[8].typ, exp_q[8].act, exp_q[8].ovr, exp_q[8].cnt},
            {3'b111, 4'b0110, 1'b1, 8'd4});
        run_warp("t3", 8'h30, 4'b0110, 0, 1, 0, 4, 1, 4, 4);

        // 4: empty mask finishes without fetching
        run_warp("t4", 8'h50, 4'b0000, 0, 0, 0, 0, 0, 0, 0);

        // 5: PC wraps from 0xFF to 0x00; LOAD issued like any op
        mem[8'hFF] = instr(3'b110, 7, 0, 0, 0);
        mem[8'h00] = instr(3'b111, 0, 0, 0, 0);
        lat = 0;
        build(8'hFF, 4'b0001, 0);
        chk("t5_model_wrap_addr", 64'(exp_q[2].addr), 64'h00);
        run_warp("t5", 8'hFF, 4'b0001, 0, 0, 0, 2, 0, 2, 1);

        // 6: async reset during FETCH, then a normal warp
        lat = 6;
        base_pc = 8'h40; lane_mask = 4'hF; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("t6_req_before_rst", 64'(imem_req), 64'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("t6_async_reset", 64'(get_obs()), 64'(rst_obs));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_idle_after_rst", 64'(get_obs()), 64'(rst_obs));
        run_warp("t6", 8'h10, 4'b1011, 1, 2, 0, 2, 0, 4, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
